ysyx_22041752_pipe_aser: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the EXU ALU path. The WIDTH-bit carry chain is split into

---
 rtl/ysyx_22041752_pipe_aser.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_22041752_pipe_aser.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_pipe_aser.sv
// ysyx_22041752_pipe_aser: pipelined add/subtract unit for the EXU ALU path.
//
// The WIDTH-bit carry chain is cut into STAGES chunks of CW = WIDTH/STAGES bits.
// Stage k adds chunk k-1 and forwards the carry into chunk k, so an op leaves the
// last stage STAGES cycles after it was accepted. The last stage also applies the
// RV64 word-mode sign extension and selects the reported carry.
//
// Build option: define ASER_FLAGS_EN to add the out_ovf/out_zero/out_lt/out_ltu
// flag ports. They are registered together with out_result.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and its payload steady until the
// transfer. in_ready is combinational from out_ready through the stage chain.
// out_* stays stable while out_valid=1 and out_ready=0.

module ysyx_22041752_pipe_aser #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic [TAG_W-1:0] out_tag
`ifdef ASER_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_lt,
    output logic             out_ltu
`endif
);

    localparam int CW = WIDTH / STAGES;
    // Sign bit of a word-mode result. It is only meaningful when WIDTH > 32.
    localparam int SB = (WIDTH > 32) ? 31 : WIDTH - 1;
    localparam bit WORD_OK = (WIDTH > 32);

    // ld[k] is high when stage k captures new contents this cycle.
    // ld[STAGES+1] stands for the consumer.
    logic [STAGES+1:1] ld;
    logic              take;

    assign ld[STAGES+1] = out_ready;
    // A flush cycle never accepts a new op.
    assign in_ready     = ld[1] & ~flush;
    assign take         = in_valid & in_ready;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        // Registered state carried by every stage
        logic             valid;
        logic [WIDTH-1:0] acc;    // chunks 0..k-1 summed, raw operand a above them
        logic             cy;     // carry into chunk k (final stage: reported cout)
        logic [TAG_W-1:0] tag;

        // Contents offered by the previous stage (or the input port)
        logic             s_valid;
        logic [WIDTH-1:0] s_acc;
        logic [WIDTH-1:0] s_b;    // effective b: already inverted for subtract
        logic             s_c;
        logic             s_sub;
        logic             s_word;
        logic             s_a31;  // raw a bit 31, needed for the word-mode carry
        logic             s_amsb; // raw a sign bit, needed for overflow
        logic [TAG_W-1:0] s_tag;

        logic [CW:0]      csum;
        logic [WIDTH-1:0] n_acc;
        logic             n_c;

        if (k == 1) begin : g_src
            assign s_valid = take;
            assign s_acc   = in_a;
            assign s_b     = in_sub ? ~in_b : in_b;
            assign s_c     = in_sub;
            assign s_sub   = in_sub;
            assign s_word  = in_word & WORD_OK;
            assign s_a31   = in_a[SB];
            assign s_amsb  = in_a[WIDTH-1];
            assign s_tag   = in_tag;
        end else begin : g_src
            assign s_valid = g_stage[k-1].valid;
            assign s_acc   = g_stage[k-1].acc;
            assign s_b     = g_stage[k-1].g_mid.bb;
            assign s_c     = g_stage[k-1].cy;
            assign s_sub   = g_stage[k-1].g_mid.sub;
            assign s_word  = g_stage[k-1].g_mid.word;
            assign s_a31   = g_stage[k-1].g_mid.a31;
            assign s_amsb  = g_stage[k-1].g_mid.amsb;
            assign s_tag   = g_stage[k-1].tag;
        end

        // This stage owns chunk k-1 of the carry chain.
        assign csum = {1'b0, s_acc[(k-1)*CW +: CW]}
                    + {1'b0, s_b[(k-1)*CW +: CW]}
                    + {{CW{1'b0}}, s_c};

        // Fold the chunk sum in. In the final stage, word mode also sign-extends
        // bit 31 and reports the carry out of bit 31 instead of the top carry.
        always_comb begin
            logic s31;
            logic b31;
            logic c31;
            n_acc = s_acc;
            n_acc[(k-1)*CW +: CW] = csum[CW-1:0];
            n_c = csum[CW];
            s31 = n_acc[SB];
            b31 = s_b[SB];
            // Carry into bit 31, recovered from that bit's sum and operand bits.
            c31 = s31 ^ s_a31 ^ b31;
            if (k == STAGES && s_word) begin
                for (int i = 32; i < WIDTH; i++) begin
                    n_acc[i] = s31;
                end
                n_c = (s_a31 & b31) | (s_a31 & c31) | (b31 & c31);
            end
        end

        // The stage loads when it is empty or when its contents move on.
        assign ld[k] = ~valid | ld[k+1];

        // Valid and payload of stage k. A flush kills the valid bit only.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid <= 1'b0;
                acc   <= '0;
                cy    <= 1'b0;
                tag   <= '0;
            end else begin
                if (flush) begin
                    valid <= 1'b0;
                end else if (ld[k]) begin
                    valid <= s_valid;
                end
                if (ld[k]) begin
                    acc <= n_acc;
                    cy  <= n_c;
                    tag <= s_tag;
                end
            end
        end

        if (k < STAGES) begin : g_mid
            logic [WIDTH-1:0] bb;
            logic             sub;
            logic             word;
            logic             a31;
            logic             amsb;

            // Operand b and the op controls move along with the partial sum.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    bb   <= '0;
                    sub  <= 1'b0;
                    word <= 1'b0;
                    a31  <= 1'b0;
                    amsb <= 1'b0;
                end else if (ld[k]) begin
                    bb   <= s_b;
                    sub  <= s_sub;
                    word <= s_word;
                    a31  <= s_a31;
                    amsb <= s_amsb;
                end
            end
        end

`ifndef ASER_FLAGS_EN
        // Without the flags, the final stage has no use for these controls.
        if (k == STAGES) begin : g_sink
            logic unused_ctl;
            assign unused_ctl = ^{s_sub, s_amsb};
        end
`endif
    end

    // The last stage register drives the result ports directly.
    assign out_valid  = g_stage[STAGES].valid;
    assign out_result = g_stage[STAGES].acc;
    assign out_cout   = g_stage[STAGES].cy;
    assign out_tag    = g_stage[STAGES].tag;

`ifdef ASER_FLAGS_EN
    logic f_ovf;
    logic f_zero;
    logic f_lt;
    logic f_ltu;

    // Flags of the op that enters the last stage, at its effective width.
    // Operand b is the effective one, so a single add-overflow rule covers subtract.
    always_comb begin
        logic sa;
        logic sb;
        logic sr;
        sa = g_stage[STAGES].s_word ? g_stage[STAGES].s_a31 : g_stage[STAGES].s_amsb;
        sb = g_stage[STAGES].s_word ? g_stage[STAGES].s_b[SB] : g_stage[STAGES].s_b[WIDTH-1];
        sr = g_stage[STAGES].s_word ? g_stage[STAGES].n_acc[SB] : g_stage[STAGES].n_acc[WIDTH-1];
        f_ovf  = (sa == sb) && (sr != sa);
        f_zero = g_stage[STAGES].s_word ? (g_stage[STAGES].n_acc[SB:0] == '0)
                                        : (g_stage[STAGES].n_acc == '0);
        f_lt   = g_stage[STAGES].s_sub & (sr ^ f_ovf);
        f_ltu  = g_stage[STAGES].s_sub & ~g_stage[STAGES].n_c;
    end

    // The flags load with out_result so they always describe the op on out_result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_lt   <= 1'b0;
            out_ltu  <= 1'b0;
        end else if (ld[STAGES]) begin
            out_ovf  <= f_ovf;
            out_zero <= f_zero;
            out_lt   <= f_lt;
            out_ltu  <= f_ltu;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22041752_pipe_aser.sv
// Bench for ysyx_22041752_pipe_aser (WIDTH=64, STAGES=2, TAG_W=5).
// Expected results come from a plain arithmetic model and a scoreboard queue of accepted ops.
// Flag checks are compiled in only when ASER_FLAGS_EN is defined.

module tb_ysyx_22041752_pipe_aser;

  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int RW     = TAG_W + 1 + WIDTH;  // {tag, cout, result}
  localparam int EW     = 4 + RW;             // {ovf, zero, lt, ltu, tag, cout, result}

  // Directed vectors: a, b, sub, word, tag, result, cout, {ovf, zero, lt, ltu}
  localparam logic [63:0] TA [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h0000_0000_7FFF_FFFF};
  localparam logic [63:0] TB [3] = '{64'd1, 64'd7, 64'd1};
  localparam logic        TS [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic        TW [3] = '{1'b0, 1'b0, 1'b1};
  localparam logic [4:0]  TT [3] = '{5'd3, 5'd9, 5'd17};
  localparam logic [63:0] TR [3] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_8000_0000};
  localparam logic        TC [3] = '{1'b1, 1'b0, 1'b0};
  localparam logic [3:0]  TF [3] = '{4'b0100, 4'b0011, 4'b1000};

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_word;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;
`ifdef ASER_FLAGS_EN
  logic             out_ovf;
  logic             out_zero;
  logic             out_lt;
  logic             out_ltu;
`endif

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ysyx_22041752_pipe_aser #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_word(in_word), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_tag(out_tag)
`ifdef ASER_FLAGS_EN
    , .out_ovf(out_ovf), .out_zero(out_zero), .out_lt(out_lt), .out_ltu(out_ltu)
`endif
  );

  // ---------------- reference model ----------------
  // The answer comes from plain arithmetic: subtract and compare operators and
  // signed range checks. There is no carry-chain bit twiddling here.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic sub, input logic word, input logic [TAG_W-1:0] tag);
    logic [WIDTH-1:0] r;
    logic co, ovf, zero, lt, ltu;
    logic [31:0] a32, b32, r32;
    longint sa, sb, sv;
    logic signed [WIDTH+1:0] wa, wb, wv;
    logic [WIDTH:0] us;
    lt = 1'b0;
    ltu = 1'b0;
    if (word) begin
      a32 = a[31:0];
      b32 = b[31:0];
      sa = longint'($signed(a32));
      sb = longint'($signed(b32));
      if (sub) begin
        r32 = a32 - b32;
        co  = (a32 >= b32);
        sv  = sa - sb;
        lt  = (sa < sb);
        ltu = (a32 < b32);
      end else begin
        r32 = a32 + b32;
        co  = (({1'b0, a32} + {1'b0, b32}) > 33'h0_FFFF_FFFF);
        sv  = sa + sb;
      end
      r    = {{(WIDTH-32){r32[31]}}, r32};
      ovf  = (sv != longint'($signed(r32)));
      zero = (r32 == 32'd0);
    end else begin
      wa = {{2{a[WIDTH-1]}}, a};
      wb = {{2{b[WIDTH-1]}}, b};
      us = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      r  = us[WIDTH-1:0];
      co = sub ? (a >= b) : us[WIDTH];
      wv = sub ? (wa - wb) : (wa + wb);
      ovf  = (wv != {{2{r[WIDTH-1]}}, r});
      zero = (r == '0);
      if (sub) begin
        lt  = (wa < wb);
        ltu = (a < b);
      end
    end
    return {ovf, zero, lt, ltu, tag, co, r};
  endfunction

  // Actual DUT output, packed in the same layout as the model.
  function automatic logic [EW-1:0] observed();
    logic [3:0] f;
    f = 4'b0;
`ifdef ASER_FLAGS_EN
    f = {out_ovf, out_zero, out_lt, out_ltu};
`endif
    return {f, out_tag, out_cout, out_result};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [TAG_W-1:0] tag);
    int pick;
    pick   = $urandom_range(0, 7);
    in_a   = {$urandom, $urandom};
    in_b   = {$urandom, $urandom};
    if (pick == 0) in_a = '1;
    if (pick == 1) in_b = '1;
    if (pick == 2) in_a = 64'h0000_0000_7FFF_FFFF;
    if (pick == 3) in_b = 64'h8000_0000_8000_0000;
    if (pick == 4) in_b = in_a;
    in_sub  = 1'($urandom_range(0, 1));
    in_word = 1'($urandom_range(0, 1));
    in_tag  = tag;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_word = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++;
    if (observed() !== '0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", observed()); end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_directed;
    logic [EW-1:0] obs;
    logic [RW-1:0] exp_lo;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = TA[i]; in_b = TB[i]; in_sub = TS[i]; in_word = TW[i]; in_tag = TT[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b exp 1", i, in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 1; c < STAGES; c++) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid: got %b exp 0", i, out_valid); end
        @(negedge clk);
      end
      obs = observed();
      exp_lo = {TT[i], TC[i], TR[i]};
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: got valid %b exp 1", i, out_valid); end
      checks++;
      if (obs[RW-1:0] !== exp_lo) begin errors++; $display("FAIL dir%0d_result: got %h exp %h", i, obs[RW-1:0], exp_lo); end
`ifdef ASER_FLAGS_EN
      checks++;
      if (obs[EW-1:RW] !== TF[i]) begin errors++; $display("FAIL dir%0d_flags: got %b exp %b", i, obs[EW-1:RW], TF[i]); end
`endif
    end
  endtask

  task automatic test_back_to_back;
    int sent, got, cyc;
    logic hold, full_seen;
    logic [EW-1:0] held, obs, exp;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; full_seen = 1'b0; held = '0;
    exp_q.delete();
    while ((sent < 8 || exp_q.size() != 0) && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = (sent < 8);
      if (sent < 8) drive_op(TAG_W'(sent + 1));
      #1;
      obs = observed();
      checks++;
      if (in_ready !== ((exp_q.size() < STAGES) || out_ready)) begin
        errors++; $display("FAIL b2b_in_ready cyc%0d: got %b occupancy %0d", cyc, in_ready, exp_q.size());
      end
      if (in_ready === 1'b0) full_seen = 1'b1;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held) begin
          errors++; $display("FAIL b2b_hold cyc%0d: got %h exp %h", cyc, obs, held);
        end
      end
      if (out_valid === 1'b1 && exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL b2b_spurious cyc%0d: got %h exp none", cyc, obs);
      end else if (out_valid === 1'b1 && out_ready) begin
        exp = exp_q.pop_front();
        got++;
        checks++;
        if (obs[RW-1:0] !== exp[RW-1:0]) begin errors++; $display("FAIL b2b_result: got %h exp %h", obs[RW-1:0], exp[RW-1:0]); end
`ifdef ASER_FLAGS_EN
        checks++;
        if (obs[EW-1:RW] !== exp[EW-1:RW]) begin errors++; $display("FAIL b2b_flags: got %b exp %b", obs[EW-1:RW], exp[EW-1:RW]); end
`endif
      end
      hold = (out_valid === 1'b1) && !out_ready;
      held = obs;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(in_a, in_b, in_sub, in_word, in_tag));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != 8 || got != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got sent=%0d recv=%0d exp 8/8", sent, got);
    end
    checks++;
    if (!full_seen) begin errors++; $display("FAIL b2b_full: got in_ready never 0 exp 0 when full"); end
  endtask

  task automatic test_random;
    int cyc, got, tagc;
    logic hold;
    logic [EW-1:0] held, obs, exp;
    cyc = 0; got = 0; tagc = 0; hold = 1'b0; held = '0;
    exp_q.delete();
    while ((cyc < 300 || exp_q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      in_valid  = (cyc < 300) && ($urandom_range(0, 3) != 0);
      out_ready = (cyc >= 300) || ($urandom_range(0, 3) != 0);
      drive_op(TAG_W'(tagc));
      #1;
      obs = observed();
      checks++;
      if (in_ready !== ((exp_q.size() < STAGES) || out_ready)) begin
        errors++; $display("FAIL rnd_in_ready cyc%0d: got %b occupancy %0d", cyc, in_ready, exp_q.size());
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held) begin
          errors++; $display("FAIL rnd_hold cyc%0d: got %h exp %h", cyc, obs, held);
        end
      end
      if (out_valid === 1'b1 && exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL rnd_spurious cyc%0d: got %h exp none", cyc, obs);
      end else if (out_valid === 1'b1 && out_ready) begin
        exp = exp_q.pop_front();
        got++;
        checks++;
        if (obs[RW-1:0] !== exp[RW-1:0]) begin errors++; $display("FAIL rnd_result: got %h exp %h", obs[RW-1:0], exp[RW-1:0]); end
`ifdef ASER_FLAGS_EN
        checks++;
        if (obs[EW-1:RW] !== exp[EW-1:RW]) begin errors++; $display("FAIL rnd_flags: got %b exp %b", obs[EW-1:RW], exp[EW-1:RW]); end
`endif
      end
      hold = (out_valid === 1'b1) && !out_ready;
      held = obs;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(in_a, in_b, in_sub, in_word, in_tag));
        tagc++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || got == 0) begin
      errors++; $display("FAIL rnd_drain: got left=%0d recv=%0d exp left=0", exp_q.size(), got);
    end
  endtask

  task automatic test_flush;
    logic [EW-1:0] exp, obs;
    logic seen;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; drive_op(TAG_W'(10 + i));
      @(posedge clk);
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; drive_op(5'd12);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0", out_valid); end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; drive_op(5'd30);
    exp = model(in_a, in_b, in_sub, in_word, in_tag);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_next_ready: got %b exp 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        obs = observed();
        checks++;
        if (obs[RW-1:0] !== exp[RW-1:0]) begin errors++; $display("FAIL flush_next_result: got %h exp %h", obs[RW-1:0], exp[RW-1:0]); end
        checks++;
        if (c != STAGES - 1) begin errors++; $display("FAIL flush_next_latency: got %0d exp %0d", c, STAGES - 1); end
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL flush_timeout: got no out_valid exp one result"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [EW-1:0] exp, obs;
    logic seen;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; drive_op(TAG_W'(20 + i));
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b exp 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", out_valid); end
    checks++;
    if (observed() !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h exp 0", observed()); end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; drive_op(5'd7);
    exp = model(in_a, in_b, in_sub, in_word, in_tag);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b exp 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        obs = observed();
        checks++;
        if (obs[RW-1:0] !== exp[RW-1:0]) begin errors++; $display("FAIL rstmid_result: got %h exp %h", obs[RW-1:0], exp[RW-1:0]); end
`ifdef ASER_FLAGS_EN
        checks++;
        if (obs[EW-1:RW] !== exp[EW-1:RW]) begin errors++; $display("FAIL rstmid_flags: got %b exp %b", obs[EW-1:RW], exp[EW-1:RW]); end
`endif
        checks++;
        if (c != STAGES - 1) begin errors++; $display("FAIL rstmid_latency: got %0d exp %0d", c, STAGES - 1); end
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_timeout: got no out_valid exp one result"); end
    @(negedge clk);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
